// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP filter/bypass switch controller.
// Holds the controller state encoding used by the RTL, status readback decode and the bench,
// plus a helper that sizes the sequencing down-counter.
package dsp_pkg;

  // Controller state encoding as seen on o_state.
  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_RESET  = 2'd1,
    ST_FILL   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam int unsigned STATE_W = 2;

  // Counter width: wide enough for max(a, b) - 1, never less than one bit.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dspswitch_ctrl_if.sv
// Control/status bundle between the register bank and the filter/bypass switch controller.
// Signals:
//   i_req             requested filter enable (level)
//   i_ce              sample strobe shared with filter and switch
//   o_en              switch select, 1 = filtered path
//   o_filter_reset_n  synchronous active-low filter reset
//   o_busy            sequencing in progress (RESET or FILL)
//   o_state           current controller state for status readback
interface dspswitch_ctrl_if;
  import dsp_pkg::*;

  logic               i_req;
  logic               i_ce;
  logic               o_en;
  logic               o_filter_reset_n;
  logic               o_busy;
  logic [STATE_W-1:0] o_state;

  // Register bank / test side.
  modport master (
    output i_req, i_ce,
    input  o_en, o_filter_reset_n, o_busy, o_state
  );

  // Controller side.
  modport slave (
    input  i_req, i_ce,
    output o_en, o_filter_reset_n, o_busy, o_state
  );
endinterface

// File: rtl/dspswitch_ctrl.sv
// Glitch-free sequencing controller for the filter/bypass output switch.
// On enable the filter is held in reset for RESET_CYCLES clocks, then the pipeline is
// allowed to refill for FILL_SAMPLES qualified samples before the filtered path is selected.
// Dropping the request returns to bypass on the next edge and parks the filter in reset.
// Ports:
//   i_clk       system clock
//   i_areset_n  asynchronous active-low reset
//   bus         slave side of dspswitch_ctrl_if (i_req, i_ce in; o_en, o_filter_reset_n,
//               o_busy, o_state out, all registered)
module dspswitch_ctrl
  import dsp_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned FILL_SAMPLES = 16
) (
  input  logic             i_clk,
  input  logic             i_areset_n,
  dspswitch_ctrl_if.slave  bus
);

  localparam int unsigned CW = cnt_width(RESET_CYCLES, FILL_SAMPLES);
  localparam logic [CW-1:0] RESET_LOAD = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] FILL_LOAD  = CW'(FILL_SAMPLES - 1);

  state_t        r_state;
  state_t        w_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic          r_en;
  logic          r_filter_reset_n;
  logic          r_busy;
  logic          w_en;
  logic          w_filter_reset_n;
  logic          w_busy;

  // State, counter and output registers.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state          <= ST_BYPASS;
      r_cnt            <= '0;
      r_en             <= 1'b0;
      r_filter_reset_n <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state;
      r_cnt            <= w_cnt;
      r_en             <= w_en;
      r_filter_reset_n <= w_filter_reset_n;
      r_busy           <= w_busy;
    end
  end

  // Next state, counter and next outputs. A withdrawn request beats counter completion.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;

    case (r_state)
      ST_BYPASS: begin
        w_cnt = '0;
        if (bus.i_req) begin
          w_state = ST_RESET;
          w_cnt   = RESET_LOAD;
        end
      end
      ST_RESET: begin
        if (!bus.i_req) begin
          w_state = ST_BYPASS;
          w_cnt   = '0;
        end else if (r_cnt == '0) begin
          w_state = ST_FILL;
          w_cnt   = FILL_LOAD;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      ST_FILL: begin
        if (!bus.i_req) begin
          w_state = ST_BYPASS;
          w_cnt   = '0;
        end else if (bus.i_ce) begin
          if (r_cnt == '0) begin
            w_state = ST_ACTIVE;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt - CW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        w_cnt = '0;
        if (!bus.i_req) begin
          w_state = ST_BYPASS;
        end
      end
      default: begin
        w_state = ST_BYPASS;
        w_cnt   = '0;
      end
    endcase

    // Outputs follow the state being entered so they change on the same edge.
    w_en             = (w_state == ST_ACTIVE);
    w_filter_reset_n = (w_state == ST_FILL) || (w_state == ST_ACTIVE);
    w_busy           = (w_state == ST_RESET) || (w_state == ST_FILL);
  end

  assign bus.o_state          = r_state;
  assign bus.o_en             = r_en;
  assign bus.o_filter_reset_n = r_filter_reset_n;
  assign bus.o_busy           = r_busy;

endmodule
